// File: rtl/bcd_counter_2digit.sv
// Two-digit packed-BCD up/down counter with prescaler, saturating load and wrap pulse.
// Optional BCD_COUNTER_STEP_EN adds a synchronised pushbutton `step` input.
module bcd_counter_2digit #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
`ifdef BCD_COUNTER_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] bcd,
  output logic       wrap,
  output logic       load_err
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] presc, presc_d;
  logic [7:0]    bcd_d;
  logic          wrap_d, err_d;
  logic          tick, advance;
  logic [3:0]    ones, tens;

  function automatic logic [3:0] sat9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

`ifdef BCD_COUNTER_STEP_EN
  logic [2:0] step_sync;
  logic       step_edge;

  // Two-flop synchroniser plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_sync <= 3'b000;
    else        step_sync <= {step_sync[1:0], step};
  end

  assign step_edge = step_sync[1] & ~step_sync[2];
`else
  logic step_edge;
  assign step_edge = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      bcd      <= 8'h00;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      presc    <= presc_d;
      bcd      <= bcd_d;
      wrap     <= wrap_d;
      load_err <= err_d;
    end
  end

  // Next-state: load beats a step, a step beats hold; tick and step edge merge into one step
  always_comb begin
    presc_d = presc;
    bcd_d   = bcd;
    wrap_d  = 1'b0;
    err_d   = load_err;
    ones    = bcd[3:0];
    tens    = bcd[7:4];
    tick    = en && (presc == PMAX);
    advance = tick || step_edge;

    if (en) presc_d = tick ? '0 : presc + PW'(1);

    if (load) begin
      presc_d = '0;
      bcd_d   = {sat9(load_val[7:4]), sat9(load_val[3:0])};
      err_d   = (load_val[7:4] > 4'd9) || (load_val[3:0] > 4'd9);
    end else if (advance) begin
      if (up) begin
        if (ones < 4'd9) begin
          ones = ones + 4'd1;
        end else begin
          ones = 4'd0;
          if (tens < 4'd9) begin
            tens = tens + 4'd1;
          end else begin
            tens   = 4'd0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        if (ones > 4'd0) begin
          ones = ones - 4'd1;
        end else begin
          ones = 4'd9;
          if (tens > 4'd0) begin
            tens = tens - 4'd1;
          end else begin
            tens   = 4'd9;
            wrap_d = 1'b1;
          end
        end
      end
      bcd_d = {tens, ones};
    end
  end

endmodule
